// File: rtl/pipe_mem_pkg.sv
// -----------------------------------------------------------------------------
// pipe_mem_pkg
// Shared definitions for the unified-memory port arbiter: default bus widths
// and the arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package pipe_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_e;

    // Plain vector forms of the states for legacy-style state registers.
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_IF_BUSY = IF_BUSY;
    localparam logic [1:0] ST_D_BUSY  = D_BUSY;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Request/ready bus to the single-ported unified memory.
//   m_req   : request pending (held until the cycle m_ready=1)
//   m_we    : 1=write, 0=read
//   m_addr  : request address
//   m_wdata : write data
//   m_rdata : read data, valid with m_ready
//   m_ready : memory completes the request held on m_req this cycle
// master = arbiter side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;

    modport master (
        output m_req,
        output m_we,
        output m_addr,
        output m_wdata,
        input  m_rdata,
        input  m_ready
    );

    modport slave (
        input  m_req,
        input  m_we,
        input  m_addr,
        input  m_wdata,
        output m_rdata,
        output m_ready
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one variable-latency memory port between instruction fetch (IF) and
// the MEM-stage load/store. Data accesses win over fetches so MEM can drain.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request and PC
//   if_rdata/if_valid     : fetched word, one-cycle completion pulse
//   flush                 : mispredict; discard the current/pending fetch
//   mem_rd/mem_wr/mem_pred: MEM-stage load, store, predicate
//   mem_addr/mem_wdata    : load/store address and store data
//   mem_rdata/mem_done    : load result, one-cycle completion pulse
//   mbus                  : memory request/ready bus (master side)
//   stall_if/stall_mem    : pipeline hold signals
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              flush,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              mem_pred,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    mem_port_arbiter_if.master mbus,
    output logic              stall_if,
    output logic              stall_mem
);

    logic [1:0]        state_q,     state_d;
    logic              m_req_q,     m_req_d;
    logic              m_we_q,      m_we_d;
    logic [ADDR_W-1:0] m_addr_q,    m_addr_d;
    logic [DATA_W-1:0] m_wdata_q,   m_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              if_valid_q,  if_valid_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_done_q,  mem_done_d;
    logic              drop_q,      drop_d;
    logic              dop_s;

    // A squashed (predicate-false) load/store is not a data operation at all.
    assign dop_s = mem_pred & (mem_rd | mem_wr);

    assign stall_mem = dop_s & ~mem_done_q;
    assign stall_if  = stall_mem | (if_req & ~if_valid_q);

    assign mbus.m_req   = m_req_q;
    assign mbus.m_we    = m_we_q;
    assign mbus.m_addr  = m_addr_q;
    assign mbus.m_wdata = m_wdata_q;

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;

    // Next-state logic: issue in IDLE, wait for m_ready in the busy states.
    always_comb begin
        state_d     = state_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = 1'b0;
        drop_d      = drop_q;

        case (state_q)
            ST_IDLE: begin
                // A done/valid pulse this cycle means the pipeline advances at
                // this edge, so the request inputs are stale: do not re-issue.
                if (dop_s && !mem_done_q) begin
                    m_req_d   = 1'b1;
                    m_we_d    = mem_wr;
                    m_addr_d  = mem_addr;
                    m_wdata_d = mem_wdata;
                    state_d   = ST_D_BUSY;
                end else if (if_req && !flush && !if_valid_q) begin
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = if_addr;
                    state_d  = ST_IF_BUSY;
                end else begin
                    m_req_d = 1'b0;
                end
            end
            ST_IF_BUSY: begin
                if (mbus.m_ready) begin
                    m_req_d = 1'b0;
                    state_d = ST_IDLE;
                    // A fetch killed by a flush completes on the bus silently.
                    if (drop_q || flush) begin
                        drop_d = 1'b0;
                    end else begin
                        if_rdata_d = mbus.m_rdata;
                        if_valid_d = 1'b1;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            ST_D_BUSY: begin
                if (mbus.m_ready) begin
                    m_req_d    = 1'b0;
                    mem_done_d = 1'b1;
                    state_d    = ST_IDLE;
                    if (!m_we_q) begin
                        mem_rdata_d = mbus.m_rdata;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                end else begin
                    m_req_d = 1'b1;
                end
            end
            default: begin
                m_req_d = 1'b0;
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= {ADDR_W{1'b0}};
            m_wdata_q   <= {DATA_W{1'b0}};
            if_rdata_q  <= {DATA_W{1'b0}};
            if_valid_q  <= 1'b0;
            mem_rdata_q <= {DATA_W{1'b0}};
            mem_done_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus with a scoreboard: expected bus transactions, fetch results
// and load results are queued when stimulus is issued; independent monitors
// pop and compare whenever the DUT completes a bus transfer or pulses
// if_valid / mem_done.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        flush;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_pred;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stall_if;
    logic        stall_mem;

    int errors = 0;
    int checks = 0;
    int wait_cfg = 0;
    int wait_cnt = 0;

    bus_txn_t    exp_bus[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_mem[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .flush     (flush),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_pred  (mem_pred),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mbus      (bus),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Memory contents as seen by the model.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_0040: word_at = 32'h0010_0093;
            32'h0000_0044: word_at = 32'h0020_0113;
            32'h0000_0048: word_at = 32'h0030_0193;
            32'h0000_0080: word_at = 32'h0040_0213;
            32'h0000_0100: word_at = 32'hDEAD_BEEF;
            32'h0000_0104: word_at = 32'hCAFE_F00D;
            default:       word_at = 32'hBAD0_0000 | a;
        endcase
    endfunction

    // Memory model: completes a held request after wait_cfg wait cycles and
    // checks each completed transfer against the expected bus queue.
    always @(negedge clk) begin
        if (bus.m_req) begin
            if (wait_cnt >= wait_cfg) begin
                bus.m_ready = 1'b1;
                bus.m_rdata = word_at(bus.m_addr);
                wait_cnt    = 0;
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got we=%b addr=%h required no transfer",
                             bus.m_we, bus.m_addr);
                end else begin
                    bus_txn_t t;
                    t = exp_bus.pop_front();
                    check("bus_we", {31'd0, bus.m_we}, {31'd0, t.we});
                    check("bus_addr", bus.m_addr, t.addr);
                    if (t.we) begin
                        check("bus_wdata", bus.m_wdata, t.wdata);
                    end
                end
            end else begin
                bus.m_ready = 1'b0;
                wait_cnt    = wait_cnt + 1;
            end
        end else begin
            bus.m_ready = 1'b0;
            bus.m_rdata = 32'h0000_0000;
            wait_cnt    = 0;
        end
    end

    // Fetch monitor.
    always @(negedge clk) begin
        if (if_valid === 1'b1) begin
            if (exp_if.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_valid_unexpected: got rdata %h required no pulse", if_rdata);
            end else begin
                check("if_rdata", if_rdata, exp_if.pop_front());
            end
        end
    end

    // Data-access monitor.
    always @(negedge clk) begin
        if (mem_done === 1'b1) begin
            if (exp_mem.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_done_unexpected: got rdata %h required no pulse", mem_rdata);
            end else begin
                check("mem_rdata", mem_rdata, exp_mem.pop_front());
            end
        end
    end

    // Wait for if_valid; stall_if must stay high until that cycle.
    task automatic wait_if_valid(input string name, input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc) begin
            @(negedge clk);
            if (if_valid) break;
            check({name, "_stall_if"}, {31'd0, stall_if}, 32'd1);
            n++;
        end
        check({name, "_if_valid"}, {31'd0, if_valid}, 32'd1);
        check({name, "_stall_if_done"}, {31'd0, stall_if}, 32'd0);
    endtask

    // Wait for mem_done; stall_mem must stay high until that cycle.
    task automatic wait_mem_done(input string name, input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc) begin
            @(negedge clk);
            if (mem_done) break;
            check({name, "_stall_mem"}, {31'd0, stall_mem}, 32'd1);
            n++;
        end
        check({name, "_mem_done"}, {31'd0, mem_done}, 32'd1);
        check({name, "_stall_mem_done"}, {31'd0, stall_mem}, 32'd0);
    endtask

    task automatic check_drained(input string name);
        check({name, "_bus_left"}, exp_bus.size(), 32'd0);
        check({name, "_if_left"}, exp_if.size(), 32'd0);
        check({name, "_mem_left"}, exp_mem.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        flush     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_pred  = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_m_req", {31'd0, bus.m_req}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_mem_done", {31'd0, mem_done}, 32'd0);
        check("rst_m_addr", bus.m_addr, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Fetch 0x40, ready in the second cycle of m_req.
        wait_cfg = 1;
        exp_bus.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
        exp_if.push_back(32'h0010_0093);
        if_req  = 1'b1;
        if_addr = 32'h40;
        wait_if_valid("fetch", 20);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        check_drained("fetch");

        // Load 0x100 with three wait cycles.
        wait_cfg = 3;
        exp_bus.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_mem.push_back(32'hDEAD_BEEF);
        mem_pred = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = 32'h100;
        wait_mem_done("load", 20);
        mem_pred = 1'b0;
        mem_rd   = 1'b0;
        repeat (2) @(negedge clk);
        check_drained("load");

        // Squashed store: no access, no stall, no done.
        mem_pred  = 1'b0;
        mem_wr    = 1'b1;
        mem_addr  = 32'h200;
        mem_wdata = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("squash_stall_mem", {31'd0, stall_mem}, 32'd0);
            check("squash_m_req", {31'd0, bus.m_req}, 32'd0);
        end
        mem_wr = 1'b0;
        @(negedge clk);

        // Contention: store wins, fetch follows; a write keeps old mem_rdata.
        wait_cfg = 1;
        exp_bus.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h1234_5678});
        exp_bus.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
        exp_mem.push_back(32'hDEAD_BEEF);
        exp_if.push_back(32'h0020_0113);
        if_req    = 1'b1;
        if_addr   = 32'h44;
        mem_pred  = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = 32'h300;
        mem_wdata = 32'h1234_5678;
        wait_mem_done("contend", 20);
        mem_pred = 1'b0;
        mem_wr   = 1'b0;
        wait_if_valid("contend", 20);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        check_drained("contend");

        // Flush while fetch 0x48 is in flight; next request is 0x80.
        wait_cfg = 3;
        exp_bus.push_back('{we: 1'b0, addr: 32'h48, wdata: 32'h0});
        exp_bus.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0});
        exp_if.push_back(32'h0040_0213);
        if_req  = 1'b1;
        if_addr = 32'h48;
        @(negedge clk);
        @(negedge clk);
        flush   = 1'b1;
        if_addr = 32'h80;
        @(negedge clk);
        flush = 1'b0;
        wait_if_valid("flush", 30);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        check_drained("flush");

        // Minimum data latency: mem_done two cycles after dop is seen.
        wait_cfg = 0;
        exp_bus.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
        exp_mem.push_back(32'hCAFE_F00D);
        mem_pred = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = 32'h104;
        @(negedge clk);
        check("lat_cycle1_done", {31'd0, mem_done}, 32'd0);
        @(negedge clk);
        check("lat_cycle2_done", {31'd0, mem_done}, 32'd1);
        mem_pred = 1'b0;
        mem_rd   = 1'b0;
        repeat (2) @(negedge clk);
        check_drained("latency");

        // Reset in the middle of a load: request abandoned, outputs cleared.
        wait_cfg = 5;
        mem_pred = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = 32'h108;
        @(negedge clk);
        @(negedge clk);
        check("midload_m_req", {31'd0, bus.m_req}, 32'd1);
        reset    = 1'b1;
        mem_pred = 1'b0;
        mem_rd   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_m_req", {31'd0, bus.m_req}, 32'd0);
        check("midrst_m_we", {31'd0, bus.m_we}, 32'd0);
        check("midrst_m_addr", bus.m_addr, 32'h0);
        check("midrst_m_wdata", bus.m_wdata, 32'h0);
        check("midrst_mem_done", {31'd0, mem_done}, 32'd0);
        check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
        check("midrst_mem_rdata", mem_rdata, 32'h0);
        check("midrst_if_rdata", if_rdata, 32'h0);
        check("midrst_stall_mem", {31'd0, stall_mem}, 32'd0);
        check("midrst_stall_if", {31'd0, stall_if}, 32'd0);
        repeat (8) @(negedge clk);
        check("midrst_idle_m_req", {31'd0, bus.m_req}, 32'd0);
        check_drained("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates a single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (loads/stores held in the EX-to-MEM pipeline register). Drives the pipeline stall signals that gate IF and the pipeline registers up to MEM. Honours the MEM-stage predicate: a squashed load/store never reaches memory. Handles branch-mispredict flush by discarding in-flight fetches.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
if_req  in  1  IF stage requests an instruction at if_addr
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction; valid when if_valid=1
if_valid  out  1  one-cycle pulse, fetch complete
flush  in  1  mispredict flush; kill current/pending fetch
mem_rd  in  1  MEM-stage load (MEMRd_mem)
mem_wr  in  1  MEM-stage store (MEMWr_mem)
mem_pred  in  1  MEM-stage predicate (Predicate_mem)
mem_addr  in  ADDR_W  load/store address (Res_mem)
mem_wdata  in  DATA_W  store data (Data_mem)
mem_rdata  out  DATA_W  load result; valid when mem_done=1
mem_done  out  1  one-cycle pulse, data access complete
m_req  out  1  memory request
m_we  out  1  1=write, 0=read
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid with m_ready
m_ready  in  1  memory completes the request held on m_req this cycle
stall_if  out  1  hold PC and IF/ID register
stall_mem  out  1  hold all pipeline registers up to and including EX-to-MEM

Behaviour:
- dop = mem_pred & (mem_rd | mem_wr). mem_rd & mem_wr together: treated as a write.
- FSM states: IDLE, IF_BUSY, D_BUSY. Reset -> IDLE; all registered outputs 0 (m_req, m_we, m_addr, m_wdata, if_rdata, if_valid, mem_rdata, mem_done, drop flag).
- IDLE priority: data over fetch (MEM must drain first).
  - dop & ~mem_done -> register m_req=1, m_we=mem_wr, m_addr=mem_addr, m_wdata=mem_wdata; go D_BUSY.
  - else if_req & ~flush & ~if_valid -> m_req=1, m_we=0, m_addr=if_addr; go IF_BUSY.
  - mem_done=1 / if_valid=1 block re-issue that cycle: the pipeline register/PC advances at that edge, inputs are stale.
- m_req, m_we, m_addr, m_wdata are registered and held stable until the cycle m_ready=1; m_req drops the following edge. m_ready ignored while m_req=0.
- D_BUSY, m_ready=1: mem_rdata<=m_rdata (writes: mem_rdata unchanged), mem_done<=1 for one cycle, -> IDLE. Minimum data latency: issue edge + 1 memory cycle -> mem_done 2 cycles after dop first seen in IDLE.
- IF_BUSY: flush sets drop flag. On m_ready: if drop (or flush this cycle) -> no if_valid, clear drop; else if_rdata<=m_rdata, if_valid<=1 one cycle. -> IDLE.
- A dop arriving during IF_BUSY waits; fetch finishes first (no abort).
- stall_mem (comb) = dop & ~mem_done.
- stall_if (comb) = stall_mem | (if_req & ~if_valid).
- Predicate false: no memory access, no mem_done, stall_mem=0.
- Reset mid-transaction: m_req drops on that edge; memory abandons request; no done/valid pulse.

Decomposition:
- Shared package pipe_mem_pkg: FSM state enum (IDLE, IF_BUSY, D_BUSY, 2-bit encoding), ADDR_W/DATA_W defaults.
- Single module; no sub-module warranted.

Test Plan:
- Fetch: if_req=1, if_addr=0x40, m_ready high 2 cycles after m_req -> m_addr=0x40, m_we=0; if_valid pulses once with if_rdata=memory word; stall_if high until that cycle.
- Load: mem_pred=1, mem_rd=1, mem_addr=0x100, memory returns 0xDEADBEEF after 3 wait cycles -> stall_mem high until mem_done; mem_rdata=0xDEADBEEF; exactly one m_req transaction.
- Squashed store: mem_pred=0, mem_wr=1, mem_addr=0x200 -> m_req never asserted with m_we=1; stall_mem=0; mem_done stays 0.
- Contention: in IDLE, if_req=1 (0x44) and a predicated store (0x300, wdata 0x12345678) together -> store issued first (m_we=1, m_addr=0x300), then fetch 0x44 issued after mem_done.
- Flush: fetch 0x48 in flight, flush=1 for one cycle, then if_addr=0x80 -> 0x48 response produces no if_valid; next request m_addr=0x80.
- Reset mid-load in D_BUSY -> next cycle m_req=0, state IDLE, mem_done/if_valid=0, all outputs zero.
